// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - glyph table and nibble decode for the hex display scanner
package hex_display_pkg;

  // Active-low segment patterns, bit 0 = a .. bit 6 = g
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = GLYPH_0;
      4'h1: s = GLYPH_1;
      4'h2: s = GLYPH_2;
      4'h3: s = GLYPH_3;
      4'h4: s = GLYPH_4;
      4'h5: s = GLYPH_5;
      4'h6: s = GLYPH_6;
      4'h7: s = GLYPH_7;
      4'h8: s = GLYPH_8;
      4'h9: s = GLYPH_9;
      4'hA: s = GLYPH_A;
      4'hB: s = GLYPH_B;
      4'hC: s = GLYPH_C;
      4'hD: s = GLYPH_D;
      4'hE: s = GLYPH_E;
      default: s = GLYPH_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_display_scanner_rom.sv
// rtl/hex_display_scanner_rom.sv - combinational nibble to 7-segment glyph lookup
module hex_glyph_rom
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = nibble_to_seg(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed hex 7-segment scanner, optional blink via HEXSCAN_BLINK_EN
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
`ifdef HEXSCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(CLK_DIV - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_buf;
  logic [4*DIGITS-1:0]   disp_buf;
  logic                  tick;
  logic                  frame_evt;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     zero_from;
  logic [DIGITS-1:0]     one_hot;
  logic                  all_zero;
  logic                  lz_blank;
  logic                  blink_off;
  logic [6:0]            glyph;

  assign tick      = (presc == LAST_PRE);
  assign frame_evt = tick && (idx == LAST_IDX);

  // Slot prescaler, digit index and the frame-boundary pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= frame_evt;
      if (tick) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pend_buf and only reach disp_buf at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf <= '0;
      disp_buf <= '0;
      pending  <= 1'b0;
    end else if (load && frame_evt) begin
      pend_buf <= value;
      disp_buf <= value;
      pending  <= 1'b0;
    end else if (frame_evt && pending) begin
      disp_buf <= pend_buf;
      pending  <= 1'b0;
    end else if (load) begin
      pend_buf <= value;
      pending  <= 1'b1;
    end
  end

  // Current-digit nibble, leading-zero run from the top digit down, and anode one-hot
  always_comb begin
    nib       = 4'h0;
    all_zero  = 1'b1;
    zero_from = '0;
    one_hot   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero & (disp_buf[4*k +: 4] == 4'h0);
      zero_from[k] = all_zero;
      if (idx == IW'(k)) nib = disp_buf[4*k +: 4];
    end
    one_hot[idx] = 1'b1;
    lz_blank     = blank_lz && (idx != '0) && zero_from[idx];
  end

  hex_glyph_rom u_rom (
    .nibble (nib),
    .glyph  (glyph)
  );

`ifdef HEXSCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Frame counter toggling the blink phase every BLINK_DIV frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_evt) begin
      if (blink_cnt == LAST_BLINK) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase & blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Registered pin drivers, one cycle behind the index/display state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= (lz_blank || blink_off) ? SEG_OFF : glyph;
      an  <= ~one_hot;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

  localparam int DIGITS    = 4;
  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
`ifdef HEXSCAN_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
`ifdef HEXSCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame      (frame)
  );

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    tick1();
    load  = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      tick1();
      n++;
    end while (frame !== 1'b1 && n < 64);
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_timeout frame=%b required 1", name, frame);
    end
  endtask

  // One full frame starting right after a frame edge: slot start/end an+seg and the frame pulse
  task automatic scan_frame(input logic [27:0] exp, input string name);
    logic [3:0] exp_an;
    logic       exp_f;
    for (int k = 0; k < 4; k++) begin
      exp_an = 4'b1111 ^ (4'b0001 << k);
      for (int s = 0; s < 4; s++) begin
        tick1();
        if (s == 0 || s == 3) begin
          checks++;
          if (an !== exp_an || seg !== exp[7*k +: 7]) begin
            errors++;
            $display("FAIL %s digit%0d slot_cycle%0d an=%b seg=%h required an=%b seg=%h",
                     name, k, s, an, seg, exp_an, exp[7*k +: 7]);
          end
        end
        exp_f = (k == 3 && s == 3);
        checks++;
        if (frame !== exp_f) begin
          errors++;
          $display("FAIL %s frame digit%0d slot_cycle%0d frame=%b required %b",
                   name, k, s, frame, exp_f);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick1();
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || pending !== 1'b0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset seg=%h an=%b pending=%b frame=%b required 7f 1111 0 0",
               seg, an, pending, frame);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    scan_frame({4{7'h40}}, "first_frame");
  endtask

  task automatic test_load_mid_frame();
    repeat (5) tick1();
    drive_load(16'hA5C3);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL load_pending_set pending=%b required 1", pending);
    end
    repeat (3) tick1();
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL load_pending_hold pending=%b required 1", pending);
    end
    wait_frame("load_mid");
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL load_commit pending=%b required 0", pending);
    end
    scan_frame({7'h08, 7'h12, 7'h46, 7'h30}, "show_A5C3");
  endtask

  task automatic test_last_load_wins();
    repeat (2) tick1();
    drive_load(16'h1111);
    repeat (2) tick1();
    drive_load(16'h2222);
    wait_frame("last_load");
    scan_frame({4{7'h24}}, "show_2222");
  endtask

  task automatic test_load_on_frame();
    repeat (15) tick1();
    drive_load(16'h00F0);
    checks++;
    if (frame !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL load_on_frame frame=%b pending=%b required 1 0", frame, pending);
    end
    scan_frame({7'h40, 7'h40, 7'h0E, 7'h40}, "show_00F0");
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL load_on_frame_after pending=%b required 0", pending);
    end
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    drive_load(16'h000F);
    wait_frame("lz_000F");
    scan_frame({7'h7F, 7'h7F, 7'h7F, 7'h0E}, "lz_show_000F");
    drive_load(16'h0000);
    wait_frame("lz_0000");
    scan_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, "lz_show_0000");
    drive_load(16'h0F00);
    wait_frame("lz_0F00");
    scan_frame({7'h7F, 7'h0E, 7'h40, 7'h40}, "lz_show_0F00");
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    repeat (3) tick1();
    drive_load(16'h1234);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pending pending=%b required 1", pending);
    end
    repeat (2) tick1();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || pending !== 1'b0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid seg=%h an=%b pending=%b frame=%b required 7f 1111 0 0",
               seg, an, pending, frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    scan_frame({4{7'h40}}, "after_rst_mid");
  endtask

`ifdef HEXSCAN_BLINK_EN
  task automatic test_blink();
    logic [6:0] d0 [5];
    d0[0] = 7'h40; d0[1] = 7'h40; d0[2] = 7'h7F; d0[3] = 7'h7F; d0[4] = 7'h40;
    rst_n = 1'b0;
    tick1();
    blink_mask = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 5; f++) begin
      scan_frame({7'h40, 7'h40, 7'h40, d0[f]}, "blink");
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_load_mid_frame();
    test_last_load_wins();
    test_load_on_frame();
    test_blank_lz();
    test_reset_mid_frame();
`ifdef HEXSCAN_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
